// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES key schedule.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_RSVD = 2'd3
  } key_len_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam int         NB        = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    return 4'd4 + {1'b0, kl, 1'b0};
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic word_t inv_mix_column(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  localparam logic [7:0] INV_EXP = 8'd254;

  logic [7:0] inv;

  // x^254 is the field inverse, and maps 0 to 0 as the S-box requires
  always_comb begin
    inv = 8'h01;
    for (int b = 7; b >= 0; b--) begin
      inv = gf_mul(inv, inv);
      if (INV_EXP[b]) inv = gf_mul(inv, data);
    end
    sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a word file, indexed round-key read.
// Optional macro AES_KEY_SCHED_DECRYPT_EN adds InvMixColumns on the read path for the equivalent inverse cipher.
//   state  | meaning
//   IDLE   | waiting for start
//   EXPAND | generating one schedule word per cycle
//   READY  | schedule complete and valid
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic [3:0]            rd_round,
  input  logic                  rd_inv,
  output round_key_t            rd_key,
  output logic [3:0]            nr,
  output logic                  busy,
  output logic                  ready,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = NB * (MAX_NK + 7);

  state_t     state, state_nx;
  word_t      w [DEPTH];
  logic [5:0] i;
  logic [2:0] j;
  logic [3:0] nk;
  logic [7:0] rcon;

  logic  legal, accept, reject, last, write;
  word_t prev, sbox_in, sub, t;

  assign busy  = (state == EXPAND);
  assign ready = (state == READY);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    write    = 1'b0;
    legal    = (key_len != 2'(KL_RSVD)) && (nk_of(key_len) <= 4'(MAX_NK));
    last     = (i == (({2'b00, nr} << 2) + 6'd4));
    case (state)
      IDLE, READY: begin
        if (start) begin
          if (legal) begin
            accept   = 1'b1;
            state_nx = EXPAND;
          end else begin
            reject = 1'b1;
          end
        end
      end
      EXPAND: begin
        if (last) state_nx = READY;
        else      write    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The four S-boxes are shared between the RotWord step and the AES-256 mid-block SubWord
  always_comb begin
    prev    = w[i - 6'd1];
    sbox_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    t       = prev;
    if (j == 3'd0)                    t = sub ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4) t = sub;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.data(sbox_in[8*b +: 8]), .sub(sub[8*b +: 8]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      nk    <= '0;
      nr    <= '0;
      rcon  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) w[k] <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == EXPAND) && last;
      err   <= reject;
      if (accept) begin
        for (int k = 0; k < MAX_NK; k++)
          if (4'(k) < nk_of(key_len)) w[k] <= key[32*(MAX_NK-k)-1 -: 32];
        i    <= 6'(nk_of(key_len));
        j    <= '0;
        nk   <= nk_of(key_len);
        nr   <= nr_of(key_len);
        rcon <= RCON_INIT;
      end
      if (write) begin
        w[i] <= w[i - {2'b00, nk}] ^ t;
        i    <= i + 6'd1;
        j    <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  round_key_t fwd_key;
  logic [5:0] base;

  always_comb begin
    fwd_key = '0;
    base    = {rd_round, 2'b00};
    if (rd_round <= nr)
      fwd_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

`ifdef AES_KEY_SCHED_DECRYPT_EN
  always_comb begin
    rd_key = fwd_key;
    if (rd_inv && rd_round != 4'd0 && rd_round < nr)
      for (int c = 0; c < 4; c++) rd_key[32*c +: 32] = inv_mix_column(fwd_key[32*c +: 32]);
  end
`else
  logic unused_rd_inv;
  assign unused_rd_inv = rd_inv;
  assign rd_key        = fwd_key;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed self-checking bench for aes_key_schedule_seq using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_seq;

  localparam int MAX_NK = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [1:0]           key_len;
  logic [32*MAX_NK-1:0] key;
  logic [3:0]           rd_round;
  logic                 rd_inv;
  logic [127:0]         rd_key;
  logic [3:0]           nr;
  logic                 busy, ready, done, err;

  aes_key_schedule_seq #(.MAX_NK(MAX_NK)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .rd_round(rd_round), .rd_inv(rd_inv), .rd_key(rd_key), .nr(nr),
    .busy(busy), .ready(ready), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] k;
    int           lat;
    logic [3:0]   nr;
  } run_t;

  typedef struct {
    int           run;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  run_t runs [3];
  vec_t vecs [13];

  int checks = 0;
  int errors = 0;
  int cycles;
  bit saw_err;
  bit saw_done;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2_128  = 128'hf2c295f27a96b9435935807a7359f67f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic start_pulse(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Starts a run and counts clock edges after the accept edge until done; optional second start at edge inject
  task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input int inject);
    start_pulse(kl, k);
    cycles  = 0;
    saw_err = 1'b0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (err) saw_err = 1'b1;
      if (done) break;
      if (cycles == inject - 1) begin
        key_len = 2'd2;
        key     = KEY256;
        start   = 1'b1;
      end
    end
  endtask

  task automatic check_vecs(input int r);
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].run == r) begin
        rd_round = vecs[v].rnd;
        #1;
        chk($sformatf("run%0d_round%0d", r, vecs[v].rnd), rd_key, vecs[v].exp);
      end
    end
  endtask

`ifdef AES_KEY_SCHED_DECRYPT_EN
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] tb_inv_mix(input logic [127:0] rk);
    logic [127:0] r;
    logic [7:0]   s0, s1, s2, s3;
    for (int c = 0; c < 4; c++) begin
      s0 = rk[127-32*c -: 8];
      s1 = rk[119-32*c -: 8];
      s2 = rk[111-32*c -: 8];
      s3 = rk[103-32*c -: 8];
      r[127-32*c -: 8] = tb_mul(s0, 14) ^ tb_mul(s1, 11) ^ tb_mul(s2, 13) ^ tb_mul(s3, 9);
      r[119-32*c -: 8] = tb_mul(s0, 9)  ^ tb_mul(s1, 14) ^ tb_mul(s2, 11) ^ tb_mul(s3, 13);
      r[111-32*c -: 8] = tb_mul(s0, 13) ^ tb_mul(s1, 9)  ^ tb_mul(s2, 14) ^ tb_mul(s3, 11);
      r[103-32*c -: 8] = tb_mul(s0, 11) ^ tb_mul(s1, 13) ^ tb_mul(s2, 9)  ^ tb_mul(s3, 14);
    end
    return r;
  endfunction
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    runs[0] = '{kl: 2'd0, k: KEY128, lat: 41, nr: 4'd10};
    runs[1] = '{kl: 2'd1, k: KEY192, lat: 47, nr: 4'd12};
    runs[2] = '{kl: 2'd2, k: KEY256, lat: 53, nr: 4'd14};

    vecs[0]  = '{run: 0, rnd: 4'd0,  exp: 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{run: 0, rnd: 4'd1,  exp: R1_128};
    vecs[2]  = '{run: 0, rnd: 4'd2,  exp: R2_128};
    vecs[3]  = '{run: 0, rnd: 4'd10, exp: R10_128};
    vecs[4]  = '{run: 0, rnd: 4'd11, exp: 128'h0};
    vecs[5]  = '{run: 1, rnd: 4'd0,  exp: 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[6]  = '{run: 1, rnd: 4'd1,  exp: 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    vecs[7]  = '{run: 1, rnd: 4'd12, exp: 128'he98ba06f448c773c8ecc720401002202};
    vecs[8]  = '{run: 1, rnd: 4'd13, exp: 128'h0};
    vecs[9]  = '{run: 2, rnd: 4'd0,  exp: 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[10] = '{run: 2, rnd: 4'd1,  exp: 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[11] = '{run: 2, rnd: 4'd2,  exp: 128'h9ba354118e6925afa51a8b5f2067fcde};
    vecs[12] = '{run: 2, rnd: 4'd14, exp: 128'hfe4890d1e6188d0b046df344706c631e};

    rst      = 1'b1;
    start    = 1'b0;
    key_len  = 2'd0;
    key      = '0;
    rd_round = 4'd0;
    rd_inv   = 1'b0;

    #12;
    chk("reset_busy",  busy,  0);
    chk("reset_ready", ready, 0);
    chk("reset_done",  done,  0);
    chk("reset_err",   err,   0);
    chk("reset_nr",    nr,    0);
    chk("reset_round0", rd_key, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 3; r++) begin
      run_key(runs[r].kl, runs[r].k, 0);
      chk($sformatf("run%0d_latency", r), cycles, runs[r].lat);
      chk($sformatf("run%0d_nr", r), nr, runs[r].nr);
      chk($sformatf("run%0d_ready", r), ready, 1);
      chk($sformatf("run%0d_busy", r), busy, 0);
      check_vecs(r);
      @(posedge clk);
      #1;
      chk($sformatf("run%0d_done_pulse", r), done, 0);
    end

    // Start during EXPAND must be ignored without err and without disturbing timing
    run_key(2'd0, KEY128, 5);
    chk("inject_latency", cycles, 41);
    chk("inject_no_err", saw_err, 0);
    chk("inject_nr", nr, 10);
    rd_round = 4'd10;
    #1;
    chk("inject_round10", rd_key, R10_128);

    // Reserved key length from READY: err pulse only
    start_pulse(2'd3, KEY256);
    chk("reject_err", err, 1);
    chk("reject_ready", ready, 1);
    chk("reject_busy", busy, 0);
    chk("reject_nr", nr, 10);
    rd_round = 4'd10;
    #1;
    chk("reject_round10", rd_key, R10_128);
    @(posedge clk);
    #1;
    chk("reject_err_pulse", err, 0);

    // Reset in the middle of an expansion
    start_pulse(2'd0, KEY128);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  busy,  0);
    chk("midrst_ready", ready, 0);
    chk("midrst_done",  done,  0);
    chk("midrst_nr",    nr,    0);
    rd_round = 4'd0;
    #1;
    chk("midrst_round0", rd_key, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    run_key(2'd0, KEY128, 0);
    chk("rerun_latency", cycles, 41);
    check_vecs(0);

`ifdef AES_KEY_SCHED_DECRYPT_EN
    rd_inv   = 1'b1;
    rd_round = 4'd0;
    #1;
    chk("inv_round0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_round = 4'd10;
    #1;
    chk("inv_round10", rd_key, R10_128);
    rd_round = 4'd1;
    #1;
    chk("inv_round1", rd_key, tb_inv_mix(R1_128));
    rd_round = 4'd2;
    #1;
    chk("inv_round2", rd_key, tb_inv_mix(R2_128));
`else
    rd_inv   = 1'b1;
    rd_round = 4'd1;
    #1;
    chk("inv_ignored_round1", rd_key, R1_128);
`endif
    rd_inv = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
